wb_hyperram_arbiter: RTL and testbench
======================================

# wb_hyperram_arbiter

Round-robin Wishbone arbiter that shares the single `wb_hyperram` slave port among `NUM_MASTERS` requesters, for example the Caravel management core and a user-area DMA or cache. It sits between the masters and `wb_hyperram` in the user wrapper. Each master's `cyc` acts as a bus lock. A per-access timeout aborts a hung HyperRAM transfer so the other masters are never starved.

## Interface
- `NUM_MASTERS`, default 2: number of requesters; legal range 2..4.
- `TIMEOUT`, default 255: maximum number of cycles `s_stb_o` may stay high without `s_ack_i`; 0 disables the timeout. The counter width is `$clog2(TIMEOUT+1)`.
- `wb_clk_i` — input, 1: the single clock for the whole block.
- `wb_rst_i` — input, 1: synchronous reset, active-high.
- `m_cyc_i` — input, NUM_MASTERS: per-master `cyc`.
- `m_stb_i` — input, NUM_MASTERS: per-master `stb`.
- `m_we_i` — input, NUM_MASTERS: per-master write enable.
- `m_sel_i` — input, 4*NUM_MASTERS: byte selects; master k occupies bits [4k+3:4k].
- `m_adr_i` — input, 32*NUM_MASTERS: addresses, packed the same way.
- `m_dat_i` — input, 32*NUM_MASTERS: write data, packed the same way.
- `m_ack_o` — output, NUM_MASTERS: per-master `ack`.
- `m_err_o` — output, NUM_MASTERS: per-master timeout error, a one-cycle pulse.
- `m_dat_o` — output, 32: read data broadcast to all masters; valid only with that master's `ack`.
- `s_cyc_o`, `s_stb_o`, `s_we_o` — output, 1 each: to `wb_hyperram`.
- `s_sel_o` — output, 4: to `wb_hyperram`.
- `s_adr_o` — output, 32: to `wb_hyperram`.
- `s_dat_o` — output, 32: to `wb_hyperram`.
- `s_ack_i` — input, 1: from `wb_hyperram`.
- `s_dat_i` — input, 32: from `wb_hyperram`.
- `grant_o` — output, 2: index of the granted master; valid while `busy_o` is high.
- `busy_o` — output, 1: high in state GRANT.

## Operation
- State machine with three states: IDLE, GRANT and ABORT.
- Registered state: `state`, `grant` (index), `last` (last granted index), and `tcnt` (timeout counter).
- A master requests when `m_cyc_i[k] & m_stb_i[k]`.

**IDLE**
- If any master requests, the arbiter picks the first requester scanning `last+1, last+2, …` modulo `NUM_MASTERS`.
- On that clock edge it sets `grant` and `last` to that index, moves to GRANT and clears `tcnt`.

**GRANT**
- The slave bus is driven combinationally from master `grant`:
  - `s_cyc_o = m_cyc_i[grant]` and `s_stb_o = m_stb_i[grant]`.
  - `we`, `sel`, `adr` and `dat` are muxed from master `grant`.
- Responses go only to the granted master:
  - `m_ack_o[grant] = s_ack_i`; all other `m_ack_o` bits are 0.
  - `m_dat_o = s_dat_i`.
- The grant is held as long as `m_cyc_i[grant]` stays high, so multiple strobed accesses form a locked burst.
- When `m_cyc_i[grant]` is low at a clock edge, the state returns to IDLE.

**Timeout**
- In GRANT, `tcnt` increments every cycle with `s_stb_o & ~s_ack_i`, and clears on `s_ack_i` or when `s_stb_o` is low.
- If `TIMEOUT != 0` and `tcnt == TIMEOUT-1` with `s_stb_o & ~s_ack_i`, the next state is ABORT.

**ABORT**
- Lasts exactly one cycle.
- `s_cyc_o` and `s_stb_o` are forced to 0 and `m_err_o[grant]` is 1.
- The next state is IDLE.
- A late `s_ack_i` arriving in ABORT or IDLE is dropped and not forwarded.

**Rules**
- Outside GRANT, all `s_*` outputs are 0 and all `m_ack_o` bits are 0.
- `m_err_o` is 0 except in ABORT.
- Reset in the middle of an access drops `s_cyc_o` in the cycle after the reset edge, with no ack or err issued.
- `wb_hyperram` tolerates a `cyc` drop mid-transfer; its own FSM handles that case.

## Timing
- **Reset values:**
  - state = IDLE, `grant` = 0, `last` = `NUM_MASTERS-1` (so master 0 wins first), `tcnt` = 0.
  - All outputs are 0.
- **Grant latency:** a request first seen at edge t is driven on `s_stb_o` in cycle t+1, since the slave signals are combinational from `grant`.
- **Release latency:**
  - The granted master drops `cyc` in cycle c, and `s_cyc_o` drops in that same cycle.
  - IDLE occupies cycle c+1, and the next grant is visible in cycle c+2. This gives one mandatory idle cycle between owners.
- **Ack path:** `s_ack_i` to `m_ack_o` is zero-latency combinational, so the arbiter adds no cycles per beat.
- **Abort timing:** ABORT begins exactly `TIMEOUT` cycles after the first unacked strobe cycle. `m_err_o` is a single-cycle pulse.
- **Simultaneous requests:** resolved strictly by round-robin. A master that re-requests right after its own release loses to any other waiting requester.

## Test plan
- **Single master:** reset, then master 0 does a write to address 0x100 with data 0xDEADBEEF and `sel=0xF`, with the slave model acking 5 cycles after `stb`. Required: `s_adr_o=0x100`, exactly one `m_ack_o[0]` pulse, `m_ack_o[1]=0`.
- **Simultaneous requests:** masters 0 and 1 request in the same cycle, both doing reads. Required:
  - master 0 is granted first, then master 1 two cycles after master 0 drops `cyc`;
  - `grant_o` sequence is 0, 1;
  - each master sees its own read data (0x11111111 and 0x22222222).
- **Locked burst:** master 1 holds `cyc` for 4 acked beats while master 0 requests throughout. Required: no switch until master 1 drops `cyc`, and `s_cyc_o` is continuous for all 4 beats.
- **Timeout:** `TIMEOUT=8`, slave never acks. Required:
  - `s_stb_o` high for 8 cycles;
  - then one cycle with `s_cyc_o=0` and `m_err_o[granted]=1`;
  - return to IDLE, and a pending other master is granted next.
- **Late ack after abort:** after a timeout, the slave asserts `s_ack_i` in the ABORT or IDLE cycle. Required: no `m_ack_o` bit asserts.
- **Reset mid-burst:** assert `wb_rst_i` during a granted read. Required: next cycle all outputs are 0 and `busy_o=0`; the first request after reset goes to master 0 under round-robin.

Source files
------------

// File: rtl/wb_hyperram_arbiter.sv
// rtl/wb_hyperram_arbiter.sv - round-robin Wishbone arbiter sharing one wb_hyperram slave port
// A granted master owns the slave until it drops cyc; strobes left unacked too long are aborted.
module wb_hyperram_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [31:0]               m_dat_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [3:0]                s_sel_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  input  logic                      s_ack_i,
  input  logic [31:0]               s_dat_i,
  output logic [1:0]                grant_o,
  output logic                      busy_o
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_q, last_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;

  logic [NUM_MASTERS-1:0] req;
  logic            pick_vld;
  logic [1:0]      pick_idx;
  logic            g_cyc, g_stb, g_we, stall;
  logic [3:0]      g_sel;
  logic [31:0]     g_adr, g_dat;

  assign req = m_cyc_i & m_stb_i;

  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_sel = '0;
    g_adr = '0;
    g_dat = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q == 2'(k)) begin
        g_cyc = m_cyc_i[k];
        g_stb = m_stb_i[k];
        g_we  = m_we_i[k];
        g_sel = m_sel_i[4*k +: 4];
        g_adr = m_adr_i[32*k +: 32];
        g_dat = m_dat_i[32*k +: 32];
      end
    end
  end

  // Lowest requester above last wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req[k] && (2'(k) <= last_q)) begin
        pick_vld = 1'b1;
        pick_idx = 2'(k);
      end
    end
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req[k] && (2'(k) > last_q)) begin
        pick_vld = 1'b1;
        pick_idx = 2'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    stall   = g_stb & ~s_ack_i;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          grant_d = pick_idx;
          last_d  = pick_idx;
          tcnt_d  = '0;
        end
      end
      GRANT: begin
        tcnt_d = stall ? tcnt_q + TW'(1) : '0;
        if (!g_cyc) begin
          state_d = IDLE;
        end else if ((TIMEOUT != 0) && stall && (tcnt_q == TLAST)) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = '0;
    if (state_q == GRANT) begin
      s_cyc_o = g_cyc;
      s_stb_o = g_stb;
      s_we_o  = g_we;
      s_sel_o = g_sel;
      s_adr_o = g_adr;
      s_dat_o = g_dat;
      m_dat_o = s_dat_i;
    end
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q == 2'(k)) begin
        m_ack_o[k] = (state_q == GRANT) & s_ack_i;
        m_err_o[k] = (state_q == ABORT);
      end
    end
  end

  assign busy_o  = (state_q == GRANT);
  assign grant_o = grant_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'(NUM_MASTERS - 1);
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_wb_hyperram_arbiter.sv
// tb/tb_wb_hyperram_arbiter.sv - directed and randomized bench for wb_hyperram_arbiter
// Master and slave behaviour live in the bench; an owner/abort model predicts every cycle.
`timescale 1ns/1ps
module tb_wb_hyperram_arbiter;
  localparam int N   = 2;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  m_cyc, m_stb, m_we;
  logic [4*N-1:0]  m_sel;
  logic [32*N-1:0] m_adr, m_dat;
  logic [N-1:0]  m_ack_o, m_err_o;
  logic [31:0]   m_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic          s_ack;
  logic [31:0]   s_dat;
  logic [1:0]    grant_o;
  logic          busy_o;

  wb_hyperram_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_dat_o(m_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack),
    .s_dat_i(s_dat), .grant_o(grant_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit chk_en = 1'b0;

  logic [31:0] mem [16];
  bit          act [N];
  int          left [N];
  bit          mwe [N];
  logic [3:0]  msel [N];
  logic [31:0] madr [N];
  logic [31:0] mdat [N];
  bit          gap [N];
  bit          rnd_mode = 1'b0;

  int          wait_cnt = 0;
  int          dly = 1;
  bit          never_ack = 1'b0;
  bit          late_mode = 1'b0;
  int          late_left = 0;
  bit          ack_next = 1'b0;
  logic [31:0] dat_next = '0;

  int md_owner = -1;
  int md_err   = -1;
  int md_last  = N - 1;
  int md_stall = 0;

  logic [127:0] ob_all;
  int ack_seen [N];
  int err_seen [N];
  int first_g [N];
  int done_cyc [N];
  logic [31:0] rd_last [N];
  int gseq [$];
  bit prev_busy = 1'b0;
  int stb_cycles, first_stb, stb_g0, cyc_g1, err_cyc;
  logic err_scyc;
  logic [31:0] seen_adr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc_n);
    end
  endtask

  task automatic clr_stats();
    for (int m = 0; m < N; m++) begin
      ack_seen[m] = 0; err_seen[m] = 0; first_g[m] = -1; done_cyc[m] = -1; rd_last[m] = '0;
    end
    gseq.delete();
    stb_cycles = 0; first_stb = -1; stb_g0 = 0; cyc_g1 = 0; err_cyc = -1; err_scyc = 1'b1;
    seen_adr = '0;
  endtask

  task automatic start_job(input int m, input int beats, input bit we,
                           input logic [31:0] adr, input logic [31:0] dat);
    act[m] = 1'b1; left[m] = beats; mwe[m] = we; madr[m] = adr; mdat[m] = dat; gap[m] = 1'b0;
    msel[m] = rnd_mode ? 4'($urandom_range(1, 15)) : 4'hF;
  endtask

  task automatic drive_inputs();
    for (int m = 0; m < N; m++) begin
      m_cyc[m] = act[m];
      m_stb[m] = act[m] & ~gap[m];
      m_we[m]  = mwe[m];
      m_sel[4*m +: 4]  = msel[m];
      m_adr[32*m +: 32] = madr[m];
      m_dat[32*m +: 32] = mdat[m];
    end
    s_ack = ack_next || (late_left > 0);
    s_dat = dat_next;
    if (late_left > 0) late_left--;
  endtask

  task automatic model_check();
    logic [70:0] exp_s;
    logic [N-1:0] ea, ee;
    logic [31:0] ed;
    exp_s = '0; ea = '0; ee = '0; ed = '0;
    if (md_owner >= 0) begin
      exp_s = {m_cyc[md_owner], m_stb[md_owner], m_we[md_owner], m_sel[4*md_owner +: 4],
               m_adr[32*md_owner +: 32], m_dat[32*md_owner +: 32]};
      ea[md_owner] = s_ack;
      ed = s_dat;
      check("grant", 128'(grant_o), 128'(md_owner));
    end else if (md_err >= 0) begin
      ee[md_err] = 1'b1;
    end
    check("sbus", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}, exp_s);
    check("mresp", {m_ack_o, m_err_o, busy_o, m_dat_o}, {ea, ee, (md_owner >= 0), ed});
  endtask

  task automatic observe();
    ob_all = {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
              m_ack_o, m_err_o, m_dat_o, grant_o, busy_o};
    if (s_stb_o) begin
      stb_cycles++;
      seen_adr = s_adr_o;
      if (first_stb < 0) first_stb = cyc_n;
    end
    if (busy_o && !prev_busy) gseq.push_back(int'(grant_o));
    prev_busy = busy_o;
    for (int m = 0; m < N; m++) begin
      if (m_ack_o[m]) ack_seen[m]++;
      if (m_err_o[m]) begin
        err_seen[m]++; err_cyc = cyc_n; err_scyc = s_cyc_o;
      end
      if (busy_o && (int'(grant_o) == m) && first_g[m] < 0) first_g[m] = cyc_n;
    end
    if (busy_o && grant_o == 2'd0 && s_stb_o) stb_g0++;
    if (busy_o && grant_o == 2'd1 && s_cyc_o) cyc_g1++;
  endtask

  task automatic master_update();
    for (int m = 0; m < N; m++) begin
      if (act[m] && m_ack_o[m]) begin
        if (!mwe[m]) begin
          check("rdata", m_dat_o, mem[madr[m][5:2]]);
          rd_last[m] = m_dat_o;
        end
        left[m]--;
        madr[m] = madr[m] + 32'd4;
        mdat[m] = $urandom;
        gap[m]  = rnd_mode && ($urandom_range(0, 3) == 0);
        if (left[m] == 0) begin
          act[m] = 1'b0; gap[m] = 1'b0; done_cyc[m] = cyc_n;
        end
      end else if (gap[m]) begin
        gap[m] = 1'b0;
      end
      if (m_err_o[m]) begin
        act[m] = 1'b0; gap[m] = 1'b0;
      end
    end
  endtask

  task automatic slave_update();
    bit strobe;
    strobe = s_cyc_o & s_stb_o;
    if (strobe && s_ack && s_we_o)
      for (int b = 0; b < 4; b++)
        if (s_sel_o[b]) mem[s_adr_o[5:2]][8*b +: 8] = s_dat_o[8*b +: 8];
    if (strobe && !s_ack) begin
      wait_cnt++;
      if (wait_cnt == 1 && rnd_mode) dly = $urandom_range(1, 12);
    end else begin
      wait_cnt = 0;
    end
    if (late_mode && wait_cnt == TMO) late_left = 2;
    ack_next = strobe && !s_ack && !never_ack && (wait_cnt >= dly);
    dat_next = mem[s_adr_o[5:2]];
  endtask

  // Owner-level view: who holds the slave, how long its strobe has stalled, who is owed an error.
  task automatic model_step();
    if (rst) begin
      md_owner = -1; md_err = -1; md_last = N - 1; md_stall = 0;
    end else if (md_owner >= 0) begin
      if (!m_cyc[md_owner]) begin
        md_owner = -1;
      end else if (m_stb[md_owner] && !s_ack) begin
        md_stall++;
        if (md_stall == TMO) begin
          md_err = md_owner; md_owner = -1;
        end
      end else begin
        md_stall = 0;
      end
    end else if (md_err >= 0) begin
      md_err = -1;
    end else begin
      for (int i = 1; i <= N; i++) begin
        int k = (md_last + i) % N;
        if (md_owner < 0 && m_cyc[k] && m_stb[k]) begin
          md_owner = k; md_last = k; md_stall = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    drive_inputs();
    @(negedge clk);
    if (chk_en) model_check();
    observe();
    master_update();
    slave_update();
    model_step();
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int i = 0;
    while ((act[0] || act[1]) && i < budget) begin
      cycle();
      i++;
    end
    check(tag, 128'(act[0] | act[1]), 128'(0));
  endtask

  initial begin
    int start, i;
    rst = 1'b1;
    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    for (int m = 0; m < N; m++) begin
      act[m] = 1'b0; left[m] = 0; mwe[m] = 1'b0; msel[m] = 4'h0;
      madr[m] = '0; mdat[m] = '0; gap[m] = 1'b0;
    end
    clr_stats();

    cycle();
    chk_en = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("reset_outs", ob_all, 128'(0));

    // single master write, slave acks 5 cycles after strobe
    clr_stats(); dly = 5;
    start_job(0, 1, 1'b1, 32'h100, 32'hDEADBEEF);
    start = cyc_n;
    run_until_idle("t1_done", 40);
    check("t1_adr", seen_adr, 32'h100);
    check("t1_ack0", 128'(ack_seen[0]), 128'(1));
    check("t1_ack1", 128'(ack_seen[1]), 128'(0));
    check("t1_mem", mem[0], 32'hDEADBEEF);
    check("t1_lat", 128'(first_stb - start), 128'(1));
    check("t1_stbcyc", 128'(stb_cycles), 128'(6));

    // simultaneous reads
    do_reset(); clr_stats(); dly = 2;
    mem[4] = 32'h11111111; mem[8] = 32'h22222222;
    start_job(0, 1, 1'b0, 32'h10, 32'h0);
    start_job(1, 1, 1'b0, 32'h20, 32'h0);
    run_until_idle("t2_done", 40);
    check("t2_nseq", 128'(gseq.size()), 128'(2));
    if (gseq.size() == 2) begin
      check("t2_seq0", 128'(gseq[0]), 128'(0));
      check("t2_seq1", 128'(gseq[1]), 128'(1));
    end
    check("t2_gap", 128'(first_g[1] - done_cyc[0]), 128'(3));
    check("t2_rd0", rd_last[0], 32'h11111111);
    check("t2_rd1", rd_last[1], 32'h22222222);

    // locked burst of master 1 while master 0 waits
    do_reset(); clr_stats(); dly = 1;
    start_job(1, 4, 1'b0, 32'h30, 32'h0);
    cycle();
    start_job(0, 1, 1'b0, 32'h0, 32'h0);
    run_until_idle("t3_done", 60);
    check("t3_ack1", 128'(ack_seen[1]), 128'(4));
    check("t3_cyc1", 128'(cyc_g1), 128'(8));
    check("t3_nseq", 128'(gseq.size()), 128'(2));
    if (gseq.size() == 2) check("t3_seq0", 128'(gseq[0]), 128'(1));

    // timeout with late acks in ABORT and IDLE
    do_reset(); clr_stats(); never_ack = 1'b1; late_mode = 1'b1;
    start_job(0, 1, 1'b0, 32'h40, 32'h0);
    cycle();
    start_job(1, 1, 1'b0, 32'h44, 32'h0);
    i = 0;
    while (err_seen[0] == 0 && i < 40) begin
      cycle();
      i++;
    end
    check("t4_err_seen", 128'(err_seen[0]), 128'(1));
    never_ack = 1'b0; late_mode = 1'b0; dly = 1;
    run_until_idle("t4_done", 40);
    check("t4_stb8", 128'(stb_g0), 128'(TMO));
    check("t4_err_scyc", 128'(err_scyc), 128'(0));
    check("t4_noack0", 128'(ack_seen[0]), 128'(0));
    check("t4_err1", 128'(err_seen[1]), 128'(0));
    check("t4_ack1", 128'(ack_seen[1]), 128'(1));
    check("t4_next", 128'(first_g[1] - err_cyc), 128'(2));

    // reset in the middle of a granted read
    do_reset(); clr_stats(); dly = 3;
    start_job(0, 3, 1'b0, 32'h50, 32'h0);
    start_job(1, 2, 1'b0, 32'h60, 32'h0);
    repeat (4) cycle();
    check("t5_busy_pre", 128'(ob_all[0]), 128'(1));
    do_reset();
    cycle();
    check("t5_rst_outs", ob_all, 128'(0));
    gseq.delete();
    run_until_idle("t5_done", 80);
    check("t5_first", 128'((gseq.size() > 0) ? gseq[0] : -1), 128'(0));

    // randomized traffic with timeouts, strobe gaps and occasional resets
    clr_stats(); rnd_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < N; m++)
        if (!act[m] && $urandom_range(0, 3) == 0)
          start_job(m, $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                    {26'($urandom), 6'($urandom_range(0, 15) * 4)}, $urandom);
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0;
    run_until_idle("rnd_drain", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
